hci_hwpe_split_interconnect: RTL and testbench
==============================================

Name: hci_hwpe_split_interconnect

Overview:
Wide-port HWPE-to-TCDM interconnect. It maps one DW-bit HCI core request onto NB_IN_CHAN = DW/WW word lanes and routes them to NB_OUT_CHAN word-interleaved banks.
- Supports misaligned start banks with carry into the next bank row.
- Supports partial grants: lanes already granted are masked and never re-issued.
- Reassembles responses so the wide port sees one r_valid per transaction.
- Sits between an HWPE streamer and the TCDM bank array, generalised over word width.

Parameters:
NB_OUT_CHAN, 8, number of TCDM banks; power of two, >= NB_IN_CHAN
DW, 128, input data width; multiple of WW
WW, 32, bank word width; 32 or 64
AW, 32, input byte-address width
AWM, 12, per-bank word-address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of lane-progress and response state
in_req_i  in  1  wide request
in_gnt_o  out  1  wide grant: all lanes granted
in_wen_i  in  1  1=read, 0=write
in_add_i  in  AW  byte address
in_be_i  in  DW/8  byte enables
in_data_i  in  DW  write data
in_r_data_o  out  DW  read data
in_r_valid_o  out  1  response valid
out_req_o  out  NB_OUT_CHAN  bank requests
out_gnt_i  in  NB_OUT_CHAN  bank grants
out_wen_o  out  NB_OUT_CHAN  bank wen
out_add_o  out  NB_OUT_CHAN*AWM  bank word addresses
out_be_o  out  NB_OUT_CHAN*WW/8  bank byte enables
out_data_o  out  NB_OUT_CHAN*WW  bank write data
out_r_data_i  in  NB_OUT_CHAN*WW  bank read data

Behaviour:
- Reset is asynchronous on rst_ni, active-low; clock is clk_i.
- Derived constants:
  - BO = log2(WW/8).
  - LSB = BO + log2(NB_OUT_CHAN).
  - off = in_add_i[LSB-1:BO].
  - row = in_add_i[LSB+AWM-1:LSB].
- Lane mapping:
  - Lane i drives bank b = (off+i) mod NB_OUT_CHAN.
  - Bank address is row+1 if off+i >= NB_OUT_CHAN, else row; result is modulo 2^AWM, so the top row wraps to 0.
  - Banks with no lane drive req/wen/be/data/add = 0.
- Grant state: register done_q[NB_IN_CHAN-1:0], one bit per lane already granted.
  - FSM state IDLE when done_q==0, PARTIAL otherwise.
- Issue: lane i requests its bank iff in_req_i & ~done_q[i]. Outputs are combinational from in_* and done_q; there is no added request latency.
- Lane grant: g[i] = issued[i] & out_gnt_i[b(i)].
- Completion: in_gnt_o = in_req_i & &(done_q | g).
  - On completion: done_q <= 0 (PARTIAL->IDLE or IDLE->IDLE).
  - Otherwise: done_q <= done_q | g (IDLE->PARTIAL).
- Initiator rules:
  - The initiator holds in_req_i and all payload stable until in_gnt_o.
  - Dropping in_req_i in PARTIAL is illegal (simulation assertion).
  - A new request may be presented the cycle after in_gnt_o.
- Per-bank response:
  - rv_q[b] <= out_req_o[b] & out_gnt_i[b]; reset 0. This applies to reads and writes.
  - A lane whose rv_q fires without completion in the preceding cycle captures its bank r_data into buf_q[i] and sets hold_q[i].
- Wide response:
  - in_r_valid_o is a registered copy of in_gnt_o: exactly 1 cycle after in_gnt_o.
  - in_r_data_o lane i = buf_q[i] if hold_q[i], else live bank r_data.
  - hold_q is cleared in the in_r_valid_o cycle.
- Back-to-back transactions overlap safely: bank response latency is fixed at 1.
- clear_i: done_q, hold_q and the rv registers go to 0 next cycle. Any pending transaction restarts from IDLE and granted lanes are re-issued; clear_i is only legal when in_req_i=0.
- Reset values: in_gnt_o=0 (in_req_i=0), in_r_valid_o=0, out_req_o=0, done_q=0, hold_q=0, buf_q=0, in_r_data_o=0.
- Reset mid-PARTIAL discards progress; no response is produced.
- Static assertions (non-synthesis): NB_IN_CHAN <= NB_OUT_CHAN, LSB+AWM <= AW, DW % WW == 0.

Optional Feature:
HCI_SPLIT_BE_SKIP_EN:
- When defined: on writes (in_wen_i=0), lanes whose be slice is all-zero are treated as already done. They are never issued, get no buffer entry, and return r_data 0.
- A write with all be=0 gets in_gnt_o in the same cycle as in_req_i, with no bank traffic, and still returns in_r_valid_o 1 cycle later.
- When undefined: every lane is always issued.

Test Plan:
NB_OUT_CHAN=8, DW=128, WW=32, AWM=12 unless stated.
- Aligned read add=0x100, all gnt=1 -> out_req_o=0x0F, all out_add=8, in_gnt_o same cycle, in_r_valid_o next cycle, data lanes 0..3 = banks 0..3.
- Misaligned read add=0x118 -> out_req_o=0xC3; banks 6,7 addr 8; banks 0,1 addr 9; in_r_data_o={bank1,bank0,bank7,bank6}.
- Partial grant: add=0x118, bank1 gnt=0 for cycles 0-1, then 1 ->
  - cycle 0: out_req_o=0xC3.
  - cycles 1-2: out_req_o=0x02.
  - in_gnt_o at cycle 2; in_r_valid_o at cycle 3; lanes 0-2 come from buf_q.
  - Checker confirms exactly one write per bank when wen=0.
- Back-to-back reads 0x100 then 0x110 with full grants -> in_r_valid_o high 2 consecutive cycles, data matches each address.
- Reset asserted in PARTIAL (done_q=0x7) -> done_q=0, out_req_o=0, no in_r_valid_o. After release, a reissued request completes normally.
- HCI_SPLIT_BE_SKIP_EN: write add=0x0, be=0x00F0 -> only bank1 requested, in_gnt_o when bank1 grants.

Source files
------------

// File: rtl/hci_hwpe_split_interconnect.sv
// Wide HWPE port onto word-interleaved TCDM banks: lane split, partial-grant tracking, response merge.
// Optional HCI_SPLIT_BE_SKIP_EN: write lanes whose byte-enable slice is all zero are never issued.
module hci_hwpe_split_interconnect #(
    parameter int unsigned NB_OUT_CHAN = 8,
    parameter int unsigned DW          = 128,
    parameter int unsigned WW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned AWM         = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          in_req_i,
    output logic                          in_gnt_o,
    input  logic                          in_wen_i,
    input  logic [AW-1:0]                 in_add_i,
    input  logic [DW/8-1:0]               in_be_i,
    input  logic [DW-1:0]                 in_data_i,
    output logic [DW-1:0]                 in_r_data_o,
    output logic                          in_r_valid_o,
    output logic [NB_OUT_CHAN-1:0]        out_req_o,
    input  logic [NB_OUT_CHAN-1:0]        out_gnt_i,
    output logic [NB_OUT_CHAN-1:0]        out_wen_o,
    output logic [NB_OUT_CHAN*AWM-1:0]    out_add_o,
    output logic [NB_OUT_CHAN*WW/8-1:0]   out_be_o,
    output logic [NB_OUT_CHAN*WW-1:0]     out_data_o,
    input  logic [NB_OUT_CHAN*WW-1:0]     out_r_data_i
);
    localparam int unsigned NB_IN_CHAN = DW / WW;
    localparam int unsigned BW         = WW / 8;
    localparam int unsigned BO         = $clog2(BW);
    localparam int unsigned OW         = $clog2(NB_OUT_CHAN);
    localparam int unsigned SUM_W      = OW + 1;
    localparam int unsigned LSB        = BO + OW;

    typedef enum logic {IDLE, PARTIAL} state_e;

    logic [OW-1:0]          off;
    logic [AWM-1:0]         row;
    logic [OW-1:0]          lane_bank [NB_IN_CHAN];
    logic [AWM-1:0]         lane_add  [NB_IN_CHAN];
    logic [OW-1:0]          rsp_bank  [NB_IN_CHAN];
    logic [NB_IN_CHAN-1:0]  skip, issued, lane_gnt, cap;
    logic [NB_IN_CHAN-1:0]  done_q, done_d, hold_q, rsp_skip_q;
    logic [NB_OUT_CHAN-1:0] rv_q;
    logic [OW-1:0]          rsp_off_q;
    logic [WW-1:0]          buf_q [NB_IN_CHAN];
    logic                   r_valid_q;
    state_e                 state;
    logic                   unused_ok;

    assign off       = in_add_i[LSB-1:BO];
    assign row       = in_add_i[LSB+AWM-1:LSB];
    assign unused_ok = ^{in_add_i[AW-1:LSB+AWM], in_add_i[BO-1:0]};

    for (genvar i = 0; i < NB_IN_CHAN; i++) begin : g_lane
        logic [OW:0] sum;
        // The carry out of off+i moves the lane into the next bank row.
        assign sum          = {1'b0, off} + SUM_W'(i);
        assign lane_bank[i] = sum[OW-1:0];
        assign lane_add[i]  = row + AWM'(sum[OW]);
        assign rsp_bank[i]  = rsp_off_q + OW'(i);
`ifdef HCI_SPLIT_BE_SKIP_EN
        assign skip[i]      = ~in_wen_i & ~(|in_be_i[i*BW +: BW]);
`else
        assign skip[i]      = 1'b0;
`endif
        assign issued[i]    = in_req_i & ~done_q[i] & ~skip[i];
        // Beats landing right after completion belong to the wide response and are read live.
        assign cap[i]       = rv_q[lane_bank[i]] & ~r_valid_q;
    end

    // NOTE: every output is given its default before the loop, so unmapped banks read 0 and no latch is inferred.
    always_comb begin
        out_req_o  = '0;
        out_wen_o  = '0;
        out_add_o  = '0;
        out_be_o   = '0;
        out_data_o = '0;
        lane_gnt   = '0;
        for (int i = 0; i < NB_IN_CHAN; i++) begin
            out_req_o[lane_bank[i]]             = issued[i];
            out_wen_o[lane_bank[i]]             = in_wen_i;
            out_add_o[lane_bank[i]*AWM +: AWM]  = lane_add[i];
            out_be_o[lane_bank[i]*BW +: BW]     = in_be_i[i*BW +: BW];
            out_data_o[lane_bank[i]*WW +: WW]   = in_data_i[i*WW +: WW];
            lane_gnt[i]                         = issued[i] & out_gnt_i[lane_bank[i]];
        end
    end

    assign in_gnt_o     = in_req_i & (&(done_q | skip | lane_gnt));
    assign done_d       = in_gnt_o ? '0 : (done_q | lane_gnt);
    assign state        = (done_q == '0) ? IDLE : PARTIAL;
    assign in_r_valid_o = r_valid_q;

    always_comb begin
        in_r_data_o = '0;
        if (r_valid_q) begin
            for (int i = 0; i < NB_IN_CHAN; i++) begin
                if (hold_q[i]) begin
                    in_r_data_o[i*WW +: WW] = buf_q[i];
                end else if (!rsp_skip_q[i]) begin
                    in_r_data_o[i*WW +: WW] = out_r_data_i[rsp_bank[i]*WW +: WW];
                end
            end
        end
    end

    // NOTE: state is updated with <= so each register samples the pre-edge values of its peers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q     <= '0;
            hold_q     <= '0;
            rv_q       <= '0;
            r_valid_q  <= 1'b0;
            rsp_off_q  <= '0;
            rsp_skip_q <= '0;
            // NOTE: the lane buffer is a handful of flops with a defined reset value, so it is reset like the rest.
            for (int i = 0; i < NB_IN_CHAN; i++) buf_q[i] <= '0;
        end else begin
            r_valid_q <= in_gnt_o;
            if (in_gnt_o) begin
                rsp_off_q  <= off;
                rsp_skip_q <= skip;
            end
            for (int i = 0; i < NB_IN_CHAN; i++) begin
                if (cap[i]) buf_q[i] <= out_r_data_i[lane_bank[i]*WW +: WW];
            end
            if (clear_i) begin
                done_q <= '0;
                hold_q <= '0;
                rv_q   <= '0;
            end else begin
                done_q <= done_d;
                rv_q   <= out_req_o & out_gnt_i;
                hold_q <= r_valid_q ? '0 : (hold_q | cap);
            end
        end
    end

`ifndef SYNTHESIS
    if (NB_IN_CHAN > NB_OUT_CHAN) begin : g_chk_chan
        $error("NB_IN_CHAN must not exceed NB_OUT_CHAN");
    end
    if (LSB + AWM > AW) begin : g_chk_aw
        $error("LSB+AWM must not exceed AW");
    end
    if (DW % WW != 0) begin : g_chk_dw
        $error("DW must be a multiple of WW");
    end

    req_held_in_partial: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state == PARTIAL && !clear_i) |-> in_req_i)
        else $error("in_req_i dropped while lanes are partially granted");
`endif

endmodule

// File: tb/tb_hci_hwpe_split_interconnect.sv
// Scoreboard bench for hci_hwpe_split_interconnect with a fixed-latency bank responder model.
module tb_hci_hwpe_split_interconnect;
    localparam int NB  = 8;
    localparam int DW  = 128;
    localparam int WW  = 32;
    localparam int AW  = 32;
    localparam int AWM = 12;
    localparam int MAX_WAIT = 20;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 clear_i;
    logic                 in_req_i;
    logic                 in_gnt_o;
    logic                 in_wen_i;
    logic [AW-1:0]        in_add_i;
    logic [DW/8-1:0]      in_be_i;
    logic [DW-1:0]        in_data_i;
    logic [DW-1:0]        in_r_data_o;
    logic                 in_r_valid_o;
    logic [NB-1:0]        out_req_o;
    logic [NB-1:0]        out_gnt_i;
    logic [NB-1:0]        out_wen_o;
    logic [NB*AWM-1:0]    out_add_o;
    logic [NB*WW/8-1:0]   out_be_o;
    logic [NB*WW-1:0]     out_data_o;
    logic [NB*WW-1:0]     out_r_data_i = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] sb_q[$];
    int wr_cnt[NB] = '{default: 0};
    int wr_base[NB];
    logic [NB-1:0] req_hist[4];
    logic [NB*AWM-1:0] add0;
    int gc;

    hci_hwpe_split_interconnect #(
        .NB_OUT_CHAN(NB), .DW(DW), .WW(WW), .AW(AW), .AWM(AWM)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_wen_i(in_wen_i),
        .in_add_i(in_add_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
        .in_r_data_o(in_r_data_o), .in_r_valid_o(in_r_valid_o),
        .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_wen_o(out_wen_o),
        .out_add_o(out_add_o), .out_be_o(out_be_o), .out_data_o(out_data_o),
        .out_r_data_i(out_r_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] bank_word(input int b, input logic [AWM-1:0] a);
        return {4'hA, 4'(b), 12'h5C3, a};
    endfunction

    // Reference mapping of a wide address onto the bank words it must return.
    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] add, input logic wen,
                                                input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        int off, row, s;
        r   = '0;
        off = int'(add[4:2]);
        row = int'(add[16:5]);
        for (int i = 0; i < 4; i++) begin
            s = off + i;
            r[i*WW +: WW] = bank_word(s % NB, AWM'(row + (s >= NB ? 1 : 0)));
`ifdef HCI_SPLIT_BE_SKIP_EN
            if (!wen && be[i*4 +: 4] == 4'h0) r[i*WW +: WW] = '0;
`else
            if (wen === 1'bx || be === 'x) r = 'x;
`endif
        end
        return r;
    endfunction

    // Bank array: fixed one-cycle read latency, counts write beats per bank.
    always @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (out_req_o[b] && out_gnt_i[b]) begin
                out_r_data_i[b*WW +: WW] <= bank_word(b, out_add_o[b*AWM +: AWM]);
                if (!out_wen_o[b]) wr_cnt[b] <= wr_cnt[b] + 1;
            end else begin
                out_r_data_i[b*WW +: WW] <= '0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && in_r_valid_o) begin
            if (sb_q.size() == 0) check("rsp_unexpected", {127'd0, in_r_valid_o}, '0);
            else check("rsp_data", in_r_data_o, sb_q.pop_front());
        end
    end

    // Starts at a negedge, holds the request until granted, returns at the following negedge.
    task automatic run_txn(input logic [AW-1:0] add, input logic wen, input logic [DW/8-1:0] be,
                           input int stall_bank, input int stall_cyc, output int gnt_cyc);
        sb_q.push_back(exp_rdata(add, wen, be));
        in_req_i  = 1'b1;
        in_add_i  = add;
        in_wen_i  = wen;
        in_be_i   = be;
        in_data_i = {4{add ^ 32'h5A5A_0000}};
        gnt_cyc   = -1;
        for (int c = 0; c < MAX_WAIT; c++) begin
            out_gnt_i = '1;
            if (c < stall_cyc) out_gnt_i[stall_bank] = 1'b0;
            #1;
            if (c < 4) req_hist[c] = out_req_o;
            if (c == 0) add0 = out_add_o;
            if (in_gnt_o) begin
                gnt_cyc = c;
                break;
            end
            @(negedge clk_i);
        end
        check("gnt_seen", {127'd0, gnt_cyc >= 0}, 128'd1);
        @(negedge clk_i);
    endtask

    task automatic idle();
        in_req_i  = 1'b0;
        out_gnt_i = '1;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; in_req_i = 1'b0; in_wen_i = 1'b1;
        in_add_i = '0; in_be_i = '1; in_data_i = '0; out_gnt_i = '1;
        #2;
        check("rst_gnt", {127'd0, in_gnt_o}, '0);
        check("rst_rvalid", {127'd0, in_r_valid_o}, '0);
        check("rst_req", {120'd0, out_req_o}, '0);
        check("rst_rdata", in_r_data_o, '0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Aligned read.
        run_txn(32'h100, 1'b1, '1, 0, 0, gc);
        check("al_req", {120'd0, req_hist[0]}, 128'h0F);
        for (int b = 0; b < 4; b++) check("al_add", {116'd0, add0[b*AWM +: AWM]}, 128'd8);
        check("al_gnt_cyc", 128'(gc), 128'd0);
        check("al_rvalid_lat", {127'd0, in_r_valid_o}, 128'd1);
        idle();

        // Misaligned read with carry into the next row.
        run_txn(32'h118, 1'b1, '1, 0, 0, gc);
        check("mis_req", {120'd0, req_hist[0]}, 128'hC3);
        check("mis_add6", {116'd0, add0[6*AWM +: AWM]}, 128'd8);
        check("mis_add7", {116'd0, add0[7*AWM +: AWM]}, 128'd8);
        check("mis_add0", {116'd0, add0[0*AWM +: AWM]}, 128'd9);
        check("mis_add1", {116'd0, add0[1*AWM +: AWM]}, 128'd9);
        idle();

        // Partial grant read: bank 1 stalls two cycles.
        run_txn(32'h118, 1'b1, '1, 1, 2, gc);
        check("pg_req0", {120'd0, req_hist[0]}, 128'hC3);
        check("pg_req1", {120'd0, req_hist[1]}, 128'h02);
        check("pg_req2", {120'd0, req_hist[2]}, 128'h02);
        check("pg_gnt_cyc", 128'(gc), 128'd2);
        check("pg_rvalid_lat", {127'd0, in_r_valid_o}, 128'd1);
        idle();

        // Partial grant write: every mapped bank takes exactly one write beat.
        wr_base = wr_cnt;
        run_txn(32'h118, 1'b0, '1, 1, 2, gc);
        idle();
        for (int b = 0; b < NB; b++)
            check("pg_wr_once", 128'(wr_cnt[b] - wr_base[b]),
                  128'((b == 0 || b == 1 || b == 6 || b == 7) ? 1 : 0));

        // Back-to-back reads.
        run_txn(32'h100, 1'b1, '1, 0, 0, gc);
        check("b2b_rvalid0", {127'd0, in_r_valid_o}, 128'd1);
        run_txn(32'h110, 1'b1, '1, 0, 0, gc);
        check("b2b_rvalid1", {127'd0, in_r_valid_o}, 128'd1);
        check("b2b_req", {120'd0, req_hist[0]}, 128'hF0);
        idle();

        // Reset while partially granted discards progress.
        in_req_i = 1'b1; in_add_i = 32'h118; in_wen_i = 1'b1; in_be_i = '1;
        out_gnt_i = 8'hFD;
        #1 check("rp_req0", {120'd0, out_req_o}, 128'hC3);
        @(negedge clk_i);
        #1 check("rp_req1", {120'd0, out_req_o}, 128'h02);
        check("rp_done", {124'd0, dut.done_q}, 128'h7);
        rst_ni = 1'b0; in_req_i = 1'b0; out_gnt_i = '1;
        #1 check("rp_req_rst", {120'd0, out_req_o}, '0);
        check("rp_done_rst", {124'd0, dut.done_q}, '0);
        repeat (2) @(negedge clk_i);
        check("rp_no_rvalid", {127'd0, in_r_valid_o}, '0);
        rst_ni = 1'b1;
        run_txn(32'h118, 1'b1, '1, 0, 0, gc);
        check("rp_reissue_req", {120'd0, req_hist[0]}, 128'hC3);
        idle();

        // Clear while idle-requested restarts lane progress.
        in_req_i = 1'b1; in_add_i = 32'h118; in_wen_i = 1'b1; in_be_i = '1;
        out_gnt_i = 8'hFD;
        @(negedge clk_i);
        in_req_i = 1'b0; clear_i = 1'b1; out_gnt_i = '1;
        #1 check("clr_req", {120'd0, out_req_o}, '0);
        @(negedge clk_i);
        clear_i = 1'b0;
        run_txn(32'h118, 1'b1, '1, 0, 0, gc);
        check("clr_reissue_req", {120'd0, req_hist[0]}, 128'hC3);
        idle();

        // Write with sparse byte enables.
        run_txn(32'h0, 1'b0, 16'h00F0, 1, 1, gc);
        check("be_gnt_cyc", 128'(gc), 128'd1);
`ifdef HCI_SPLIT_BE_SKIP_EN
        check("be_req", {120'd0, req_hist[0]}, 128'h02);
        idle();
        run_txn(32'h40, 1'b0, 16'h0000, 1, 1, gc);
        check("be0_gnt_cyc", 128'(gc), 128'd0);
        check("be0_req", {120'd0, req_hist[0]}, '0);
`else
        check("be_req", {120'd0, req_hist[0]}, 128'h0F);
`endif
        idle();
        repeat (3) @(negedge clk_i);
        check("sb_drain", 128'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
